vga_timing_gen: RTL

//  Parametrised VGA raster timing generator; next generation of the fixed 1280x1024 sync block.

---
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces raw counts, sync pulses, an active-area flag, active-area
// coordinates and line/frame strobes, all registered together so that
// every output describes the pixel currently held on hc/vc.

module vga_timing_gen #(
   parameter int   H_ACTIVE = 1280,
   parameter int   H_FP     = 48,
   parameter int   H_SYNC   = 112,
   parameter int   H_BP     = 248,
   parameter int   V_ACTIVE = 1024,
   parameter int   V_FP     = 1,
   parameter int   V_SYNC   = 3,
   parameter int   V_BP     = 38,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   CW       = 11
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          vidon,
   output logic [CW-1:0] hc,
   output logic [CW-1:0] vc,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int HA0     = H_SYNC + H_BP;
   localparam int HA_END  = HA0 + H_ACTIVE;
   localparam int VA0     = V_SYNC + V_BP;
   localparam int VA_END  = VA0 + V_ACTIVE;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] HA0_C  = CW'(HA0);
   localparam logic [CW-1:0] VA0_C  = CW'(VA0);

   // Reject counter widths too narrow for the raster and empty sync/active segments
   if ((H_TOTAL - 1) > ((1 << CW) - 1) || (V_TOTAL - 1) > ((1 << CW) - 1)) begin : gWidthCheck
      $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
   end
   if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
       H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : gSegCheck
      $error("vga_timing_gen: illegal zero-width or negative segment");
   end

   logic [CW-1:0] hc_q, vc_q, x_q, y_q;
   logic          hsync_q, vsync_q, vidon_q, line_start_q, frame_start_q;

   logic [CW-1:0] hc_d, vc_d, x_d, y_d;
   logic          hsync_d, vsync_d, vidon_d, line_start_d, frame_start_d;
   logic          hcWrap, vcWrap, inH, inV;
   logic [31:0]   hcExt, vcExt;

   // Next counts, then decode every output from those next counts so the
   // registered outputs line up with the registered counts (zero latency)
   always_comb begin
      hcWrap = (hc_q == H_LAST);
      vcWrap = (vc_q == V_LAST);

      hc_d = hcWrap ? '0 : hc_q + 1'b1;
      vc_d = vc_q;
      if (hcWrap) begin
         vc_d = vcWrap ? '0 : vc_q + 1'b1;
      end

      hcExt = 32'(hc_d);
      vcExt = 32'(vc_d);

      inH     = (hcExt >= 32'(HA0)) && (hcExt < 32'(HA_END));
      inV     = (vcExt >= 32'(VA0)) && (vcExt < 32'(VA_END));
      vidon_d = inH && inV;

      hsync_d = (hcExt < 32'(H_SYNC)) ? HS_POL : ~HS_POL;
      vsync_d = (vcExt < 32'(V_SYNC)) ? VS_POL : ~VS_POL;

      x_d = vidon_d ? (hc_d - HA0_C) : '0;
      y_d = vidon_d ? (vc_d - VA0_C) : '0;

      line_start_d  = hcWrap;
      frame_start_d = hcWrap && vcWrap;
   end

   // Output/state registers; everything advances only on a pixel tick
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         hc_q          <= '0;
         vc_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         vidon_q       <= 1'b0;
         hsync_q       <= HS_POL;
         vsync_q       <= VS_POL;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (pix_en) begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         x_q           <= x_d;
         y_q           <= y_d;
         vidon_q       <= vidon_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hc          = hc_q;
   assign vc          = vc_q;
   assign x           = x_q;
   assign y           = y_q;
   assign vidon       = vidon_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule
